// File: rtl/psum_ctrl_pkg.sv
// psum_ctrl_pkg: FSM state encoding and word-to-byte address shift for the psum BRAM controller.
package psum_ctrl_pkg;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WR   = 3'd2;
   localparam logic [2:0] S_CLR  = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;
   localparam int BYTE_SHIFT = 2;
endpackage

// File: rtl/psum_acc_adder.sv
// psum_acc_adder: combinational signed adder; saturates at signed max/min when PSUM_ACC_SAT_EN is defined,
// otherwise wraps modulo 2^W.
module psum_acc_adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
`ifdef PSUM_ACC_SAT_EN
   logic [W:0] s;
   assign s = {a[W-1], a} + {b[W-1], b};
   // Top two bits differ only on overflow; s[W] then carries the true sign.
   assign y = (s[W] != s[W-1]) ? {s[W], {(W-1){~s[W]}}} : s[W-1:0];
`else
   assign y = a + b;
`endif
endmodule

// File: rtl/psum_bram_accum_ctrl.sv
// psum_bram_accum_ctrl: read-modify-write psum accumulator and range clearer for one BRAM port,
// with PS hand-over hold; optional saturation via PSUM_ACC_SAT_EN.
module psum_bram_accum_ctrl
   import psum_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_BYTE   = 4,
   parameter int REG_WIDTH  = 32,
   parameter int IDX_WIDTH  = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
   input  logic                  i_psum_valid,
   input  logic                  i_psum_first,
   input  logic [IDX_WIDTH-1:0]  i_psum_addr,
   input  logic [DATA_WIDTH-1:0] i_psum_data,
   output logic                  o_psum_ready,
   input  logic                  i_clr_start,
   input  logic [IDX_WIDTH-1:0]  i_clr_base,
   input  logic [IDX_WIDTH:0]    i_clr_len,
   output logic                  o_clr_done,
   output logic                  o_busy,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_idat,
   input  logic [DATA_WIDTH-1:0] mem_odat,
   output logic [NUM_BYTE-1:0]   mem_wren,
   output logic                  mem_enb,
   output logic                  mem_rst
);
   logic [2:0]            state, nxt, fin;
   logic [IDX_WIDTH-1:0]  idx;
   logic [DATA_WIDTH-1:0] dat, sum;
   logic [IDX_WIDTH:0]    cnt;
   logic                  first, hold, acc, last, wr, unused;

   assign unused = ^{i_conf_ctrl[REG_WIDTH-1:3], i_conf_ctrl[1:0]};

   psum_acc_adder #(.W(DATA_WIDTH)) u_add (.a(dat), .b(mem_odat), .y(sum));

   always_comb begin
      hold = i_conf_ctrl[2];
      o_psum_ready = !rst && state == S_IDLE && !hold && !i_clr_start;
      acc = o_psum_ready && i_psum_valid;
      last = cnt[IDX_WIDTH:1] == '0;
      fin = hold ? S_HOLD : S_IDLE;
      nxt = state == S_IDLE ? (hold ? S_HOLD : i_clr_start ? S_CLR :
                               acc ? (i_psum_first ? S_WR : S_RD) : S_IDLE) :
            state == S_RD   ? S_WR :
            state == S_CLR  ? (last ? fin : S_CLR) : fin;
      wr = state == S_WR || (state == S_CLR && cnt != '0);
      mem_enb = wr || state == S_RD;
      mem_wren = {NUM_BYTE{wr}};
      mem_addr = mem_enb ? (ADDR_WIDTH'(idx) << BYTE_SHIFT) : '0;
      mem_idat = state == S_WR ? (first ? dat : sum) : '0;
      mem_rst = 1'b0;
      o_clr_done = state == S_CLR && last;
      o_busy = state != S_IDLE && state != S_HOLD;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= S_IDLE;
         idx   <= '0;
         dat   <= '0;
         cnt   <= '0;
         first <= 1'b0;
      end else begin
         state <= nxt;
         if (state == S_IDLE && !hold && i_clr_start) begin
            idx <= i_clr_base;
            cnt <= i_clr_len;
         end else if (acc) begin
            idx   <= i_psum_addr;
            dat   <= i_psum_data;
            first <= i_psum_first;
         end else if (state == S_CLR) begin
            idx <= idx + IDX_WIDTH'(1);
            cnt <= cnt - (IDX_WIDTH + 1)'(1);
         end
      end
endmodule

// File: tb/tb_psum_bram_accum_ctrl.sv
// tb_psum_bram_accum_ctrl: directed checks of accumulate, wrap/saturate, range clear, hold and reset
// against a behavioural BRAM.
module tb_psum_bram_accum_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] conf;
   logic        valid, first;
   logic [11:0] addr;
   logic [31:0] data;
   logic        ready;
   logic        clr_start;
   logic [11:0] base;
   logic [12:0] len;
   logic        done, busy;
   logic [31:0] mem_addr, mem_idat, mem_odat;
   logic [3:0]  mem_wren;
   logic        mem_enb, mem_rst;
   logic [31:0] bram [0:4095];
   int          n_wr = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          wr0;

   always #5 clk = ~clk;

   psum_bram_accum_ctrl dut (
      .clk(clk), .rst(rst), .i_conf_ctrl(conf), .i_psum_valid(valid), .i_psum_first(first),
      .i_psum_addr(addr), .i_psum_data(data), .o_psum_ready(ready), .i_clr_start(clr_start),
      .i_clr_base(base), .i_clr_len(len), .o_clr_done(done), .o_busy(busy), .mem_addr(mem_addr),
      .mem_idat(mem_idat), .mem_odat(mem_odat), .mem_wren(mem_wren), .mem_enb(mem_enb), .mem_rst(mem_rst)
   );

   always @(posedge clk)
      if (mem_enb) begin
         if (mem_wren == 4'hF) begin
            bram[mem_addr[13:2]] <= mem_idat;
            n_wr <= n_wr + 1;
         end else
            mem_odat <= bram[mem_addr[13:2]];
      end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [11:0] a, input logic [31:0] d);
      valid = 1'b1; first = 1'b1; addr = a; data = d;
      step();
      valid = 1'b0;
      step();
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_enb"}, 64'(mem_enb), 64'd0);
      chk({tag, "_wren"}, 64'(mem_wren), 64'd0);
      chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
      chk({tag, "_idat"}, 64'(mem_idat), 64'd0);
      chk({tag, "_ready"}, 64'(ready), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      rst = 1'b1; conf = '0; valid = 1'b1; first = 1'b0; addr = '0; data = '0;
      clr_start = 1'b0; base = '0; len = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_quiet("reset");
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_mem_rst", 64'(mem_rst), 64'd0);
      valid = 1'b0; rst = 1'b0;
      #1;
      chk("idle_ready", 64'(ready), 64'd1);
      // first write then accumulate on word 5
      valid = 1'b1; first = 1'b1; addr = 12'd5; data = 32'd7;
      step();
      valid = 1'b0;
      chk("first_wren", 64'(mem_wren), 64'hF);
      chk("first_addr", 64'(mem_addr), 64'h14);
      chk("first_idat", 64'(mem_idat), 64'd7);
      chk("first_busy", 64'(busy), 64'd1);
      chk("first_ready", 64'(ready), 64'd0);
      step();
      chk("idle2_ready", 64'(ready), 64'd1);
      valid = 1'b1; first = 1'b0; addr = 12'd5; data = 32'd3;
      step();
      valid = 1'b0;
      chk("rd_enb", 64'(mem_enb), 64'd1);
      chk("rd_wren", 64'(mem_wren), 64'd0);
      chk("rd_addr", 64'(mem_addr), 64'h14);
      clr_start = 1'b1; base = 12'd100; len = 13'd3;
      step();
      clr_start = 1'b0;
      chk("acc_wren", 64'(mem_wren), 64'hF);
      chk("acc_idat", 64'(mem_idat), 64'd10);
      step();
      chk("clr_ignored_busy", 64'(busy), 64'd0);
      chk("clr_ignored_enb", 64'(mem_enb), 64'd0);
      chk("bram5", 64'(bram[5]), 64'd10);
      // overflow at signed max, then underflow at signed min
      put(12'd9, 32'h7FFF_FFFF);
      valid = 1'b1; first = 1'b0; addr = 12'd9; data = 32'd1;
      step();
      valid = 1'b0;
      step();
`ifdef PSUM_ACC_SAT_EN
      chk("ovf_max", 64'(mem_idat), 64'h7FFF_FFFF);
`else
      chk("ovf_max", 64'(mem_idat), 64'h8000_0000);
`endif
      step();
      put(12'd9, 32'h8000_0000);
      valid = 1'b1; first = 1'b0; addr = 12'd9; data = 32'hFFFF_FFFF;
      step();
      valid = 1'b0;
      step();
      step();
`ifdef PSUM_ACC_SAT_EN
      chk("ovf_min", 64'(bram[9]), 64'h8000_0000);
`else
      chk("ovf_min", 64'(bram[9]), 64'h7FFF_FFFF);
`endif
      // range clear wrapping past the top word
      put(12'd4094, 32'hA); put(12'd4095, 32'hB); put(12'd0, 32'hC);
      put(12'd1, 32'hD); put(12'd2, 32'hE); put(12'd4093, 32'hF);
      clr_start = 1'b1; base = 12'd4094; len = 13'd4;
      #1;
      chk("clr_start_ready", 64'(ready), 64'd0);
      step();
      clr_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("clr_enb", 64'(mem_enb), 64'd1);
         chk("clr_wren", 64'(mem_wren), 64'hF);
         chk("clr_addr", 64'(mem_addr), 64'(((4094 + k) % 4096) * 4));
         chk("clr_idat", 64'(mem_idat), 64'd0);
         chk("clr_done", 64'(done), 64'(k == 3));
         step();
      end
      chk("clr_end_done", 64'(done), 64'd0);
      chk("clr_end_busy", 64'(busy), 64'd0);
      chk("clr_w4094", 64'(bram[4094]), 64'd0);
      chk("clr_w4095", 64'(bram[4095]), 64'd0);
      chk("clr_w0", 64'(bram[0]), 64'd0);
      chk("clr_w1", 64'(bram[1]), 64'd0);
      chk("clr_w2_kept", 64'(bram[2]), 64'hE);
      chk("clr_w4093_kept", 64'(bram[4093]), 64'hF);
      // zero-length clear
      clr_start = 1'b1; base = 12'd10; len = 13'd0;
      step();
      clr_start = 1'b0;
      chk("len0_done", 64'(done), 64'd1);
      chk("len0_enb", 64'(mem_enb), 64'd0);
      step();
      chk("len0_done_off", 64'(done), 64'd0);
      chk("len0_ready", 64'(ready), 64'd1);
      // PS takes the BRAM while a read is in flight
      put(12'd20, 32'd100);
      valid = 1'b1; first = 1'b0; addr = 12'd20; data = 32'd5;
      step();
      valid = 1'b0; conf = 32'h4;
      chk("hold_rd_enb", 64'(mem_enb), 64'd1);
      step();
      chk("hold_wr_wren", 64'(mem_wren), 64'hF);
      chk("hold_wr_idat", 64'(mem_idat), 64'd105);
      step();
      valid = 1'b1;
      #1;
      chk_quiet("hold");
      step();
      chk_quiet("hold2");
      valid = 1'b0; conf = '0;
      step();
      chk("hold_exit_ready", 64'(ready), 64'd1);
      chk("bram20", 64'(bram[20]), 64'd105);
      // reset during a read abandons the accumulate
      put(12'd30, 32'd50);
      wr0 = n_wr;
      valid = 1'b1; first = 1'b0; addr = 12'd30; data = 32'd1;
      step();
      valid = 1'b0;
      chk("rst_rd_enb", 64'(mem_enb), 64'd1);
      rst = 1'b1;
      #1;
      chk_quiet("rst_mid");
      step();
      rst = 1'b0;
      valid = 1'b1; first = 1'b1; addr = 12'd31; data = 32'd9;
      #1;
      chk("rst_rel_ready", 64'(ready), 64'd1);
      step();
      valid = 1'b0;
      chk("rst_rel_addr", 64'(mem_addr), 64'h7C);
      chk("rst_rel_idat", 64'(mem_idat), 64'd9);
      step();
      chk("rst_bram30", 64'(bram[30]), 64'd50);
      chk("rst_bram31", 64'(bram[31]), 64'd9);
      chk("rst_nwr", 64'(n_wr), 64'(wr0 + 1));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/psum_bram_accum_ctrl.md
PSUM_BRAM_ACCUM_CTRL -- requirements
Module: psum_bram_accum_ctrl

Interface
REQ-001 SHALL have these parameters, name / default / meaning: DATA_WIDTH 32 psum width; ADDR_WIDTH 32 BRAM byte-address width; NUM_BYTE 4 byte lanes; REG_WIDTH 32 control-register width; IDX_WIDTH 12 psum word-index width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_conf_ctrl, input, REG_WIDTH: control register; bit 2 = 1 means PS owns the psum BRAM.
REQ-005 SHALL have port i_psum_valid, input, 1 bit: accumulate request valid.
REQ-006 SHALL have port i_psum_first, input, 1 bit: overwrite without reading, for the first partial sum.
REQ-007 SHALL have port i_psum_addr, input, IDX_WIDTH: psum word index.
REQ-008 SHALL have port i_psum_data, input, DATA_WIDTH: signed partial sum.
REQ-009 SHALL have port o_psum_ready, output, 1 bit: request accepted when valid and ready are both 1.
REQ-010 SHALL have port i_clr_start, input, 1 bit: one-cycle pulse that starts a range clear.
REQ-011 SHALL have port i_clr_base, input, IDX_WIDTH: first word of the clear range.
REQ-012 SHALL have port i_clr_len, input, IDX_WIDTH+1: number of words to clear.
REQ-013 SHALL have port o_clr_done, output, 1 bit: one-cycle pulse when the clear finishes.
REQ-014 SHALL have port o_busy, output, 1 bit: 1 in every state except IDLE and HOLD.
REQ-015 SHALL have port mem_addr, output, ADDR_WIDTH: byte address, equal to index shifted left by 2.
REQ-016 SHALL have port mem_idat, output, DATA_WIDTH: write data.
REQ-017 SHALL have port mem_odat, input, DATA_WIDTH: BRAM read data, valid one cycle after a read.
REQ-018 SHALL have port mem_wren, output, NUM_BYTE: byte write enables, all 1s or all 0s.
REQ-019 SHALL have ports mem_enb (output, 1 bit: port enable) and mem_rst (output, 1 bit: tied 0).

Function
REQ-020 SHALL implement an FSM with states IDLE, RD, WR, CLR, HOLD, with entry priority HOLD > CLR > psum request.
REQ-021 SHALL drive o_psum_ready = 1 only in IDLE, and only when i_conf_ctrl[2]=0 and i_clr_start=0.
REQ-022 On accept with i_psum_first=0: IDLE->RD, issuing a read (mem_enb=1, mem_wren=0) and latching addr and data.
REQ-023 SHALL, in RD->WR, write latched data + mem_odat to the same address (mem_enb=1, mem_wren all 1s), then WR->IDLE.
REQ-024 On accept with i_psum_first=1: IDLE->WR, writing i_psum_data unchanged; no read is issued.
REQ-025 Throughput SHALL be one accumulate every 3 cycles (first: every 2); the write completes before the next read, so there is no RAW hazard.
REQ-026 SHALL, in CLR, write 0 to base+n for n=0..len-1, one word per cycle; CLR->IDLE with o_clr_done=1 on the last write.
REQ-027 When i_clr_len=0: no write, o_clr_done pulses the cycle after start, then IDLE.
REQ-028 Clear index SHALL wrap modulo 2^IDX_WIDTH past the top word.
REQ-029 SHALL finish an in-flight RD/WR/CLR when i_conf_ctrl[2] rises, then enter HOLD; software raises bit 2 only when o_busy=0, since the bus mux switches one cycle after the bit changes.
REQ-030 SHALL, in HOLD, drive all mem_* outputs 0 and o_psum_ready=0; HOLD->IDLE when i_conf_ctrl[2]=0.
REQ-031 SHALL ignore i_clr_start outside IDLE.
REQ-032 When mem_enb=0, mem_addr and mem_idat SHALL be 0.

Reset
REQ-033 While rst=1, SHALL hold state IDLE and all outputs 0, including o_psum_ready.
REQ-034 Reset asserted mid-operation SHALL abandon the operation with no further BRAM write.

Configuration
REQ-035 With PSUM_ACC_SAT_EN defined, the sum SHALL saturate at the signed DATA_WIDTH max/min; without it, the sum SHALL wrap modulo 2^DATA_WIDTH.

Structure
REQ-036 Package psum_ctrl_pkg SHALL hold the state encoding and the byte-shift constant (2).
REQ-037 SHALL contain one sub-module, psum_acc_adder: a combinational signed adder with the optional saturation.

Verification
REQ-038 first=1, addr 5, data 7, then first=0, addr 5, data 3 -> BRAM word 5 = 10; mem_addr = 0x14.
REQ-039 Word = 0x7FFFFFFF, accumulate +1 -> 0x7FFFFFFF with PSUM_ACC_SAT_EN, 0x80000000 without it.
REQ-040 Clear base 4094, len 4, IDX_WIDTH 12 -> words 4094, 4095, 0, 1 are zeroed; o_clr_done pulses once, 4 cycles after start.
REQ-041 i_conf_ctrl[2] rises during RD -> WR write still occurs, then HOLD; mem_* = 0 and ready = 0 until the bit clears.
REQ-042 rst pulse in RD -> no write, all outputs 0; first accept succeeds 1 cycle after release.
